// File: rtl/cm0_acg_ctrl_pkg.sv
// Shared definitions for the automatic clock-gating controller: channel state
// encodings, wake-counter width and the wake-cycle clamp.
package cm0_acg_ctrl_pkg;

    localparam int WCNT_W = 3;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAKE = 2'b01,
        ST_ON   = 2'b10,
        ST_IDLE = 2'b11
    } acg_state_e;

    // Zero would never leave WAKE, and the counter cannot count past 7.
    function automatic logic [WCNT_W-1:0] clamp_wake_cyc(input int unsigned cyc);
        logic [31:0] c;
        c = cyc;
        if (cyc == 0) return WCNT_W'(1);
        if (cyc > 7) return WCNT_W'(7);
        return c[WCNT_W-1:0];
    endfunction

endpackage

// File: rtl/cm0_acg.sv
// Integrated clock-gate cell wrapper: enable is captured while the clock is low
// so the gated clock can never produce a truncated high pulse.
module cm0_acg #(
    parameter int CBAW = 0
) (
    input  logic CLKIN,
    input  logic ENABLE,
    input  logic SE,
    output logic CLKOUT
);

    generate
        if (CBAW != 0) begin : g_and
            // Latch-free variant for flows that map gating onto dedicated clock buffers.
            assign CLKOUT = CLKIN & (ENABLE | SE);
        end else begin : g_latch
            logic en_lat;
            always_latch begin
                if (!CLKIN) en_lat <= ENABLE | SE;
            end
            assign CLKOUT = CLKIN & en_lat;
        end
    endgenerate

endmodule

// File: rtl/cm0_acg_ctrl_ch.sv
// One gated-clock channel: wake/idle FSM with hysteresis counters driving an ICG,
// plus a registered acknowledge that the channel clock is running.
module cm0_acg_ctrl_ch
    import cm0_acg_ctrl_pkg::*;
#(
    parameter int IDLE_W   = 4,
    parameter int WAKE_CYC = 1,
    parameter int ACG      = 1,
    parameter int CBAW     = 0
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              se,
    input  logic              req,
    input  logic              force_on,
    input  logic [IDLE_W-1:0] idle_lim,
    output logic              clk_out,
    output logic              ack
);

    localparam logic [WCNT_W-1:0] WAKE_LIM = clamp_wake_cyc(WAKE_CYC);

    logic icg_en;

    generate
        if (ACG != 0) begin : g_fsm
            acg_state_e        state_q, state_d;
            logic [IDLE_W-1:0] cnt_q, cnt_d;
            logic [WCNT_W-1:0] wcnt_q, wcnt_d;
            logic              ack_q, ack_d;
            logic              r;

            assign r = req | force_on;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                wcnt_d  = wcnt_q;
                case (state_q)
                    ST_OFF: begin
                        if (r) begin
                            state_d = ST_WAKE;
                            wcnt_d  = WCNT_W'(1);
                        end
                    end
                    ST_WAKE: begin
                        // A request dropped during wake still completes to ON.
                        if (wcnt_q == WAKE_LIM) state_d = ST_ON;
                        else                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    end
                    ST_ON: begin
                        if (r) begin
                            cnt_d = '0;
                        end else if (idle_lim == '0) begin
                            state_d = ST_OFF;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = IDLE_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        // >= so a limit lowered below the running count gates off at once.
                        if (r) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else if (cnt_q >= idle_lim) begin
                            state_d = ST_OFF;
                        end else if (cnt_q != '1) begin
                            cnt_d = cnt_q + IDLE_W'(1);
                        end
                    end
                    default: state_d = ST_ON;
                endcase
                ack_d = (state_d == ST_ON) || (state_d == ST_IDLE);
            end

            // Reset lands in ON so gated domains see clock edges while in reset.
            always_ff @(posedge clk_in) begin
                if (rst) begin
                    state_q <= ST_ON;
                    cnt_q   <= '0;
                    wcnt_q  <= '0;
                    ack_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    wcnt_q  <= wcnt_d;
                    ack_q   <= ack_d;
                end
            end

            assign icg_en = (state_q != ST_OFF) | force_on;
            assign ack    = ack_q;
        end else begin : g_bypass
            assign icg_en = 1'b1;
            assign ack    = 1'b1;
        end
    endgenerate

    cm0_acg #(
        .CBAW (CBAW)
    ) u_icg (
        .CLKIN  (clk_in),
        .ENABLE (icg_en),
        .SE     (se),
        .CLKOUT (clk_out)
    );

endmodule

// File: rtl/cm0_acg_ctrl.sv
// Multi-channel automatic clock-gating controller: one independent gated clock
// per channel derived from the shared root clock.
module cm0_acg_ctrl
    import cm0_acg_ctrl_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_CYC = 1,
    parameter int ACG      = 1,
    parameter int CBAW     = 0
) (
    input  logic                  CLKIN,
    input  logic                  RESET,
    input  logic                  SE,
    input  logic [NCH-1:0]        REQ,
    input  logic [NCH-1:0]        FORCE_ON,
    input  logic [NCH*IDLE_W-1:0] IDLE_LIM,
    output logic [NCH-1:0]        CLKOUT,
    output logic [NCH-1:0]        ACK
);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            cm0_acg_ctrl_ch #(
                .IDLE_W   (IDLE_W),
                .WAKE_CYC (WAKE_CYC),
                .ACG      (ACG),
                .CBAW     (CBAW)
            ) u_ch (
                .clk_in   (CLKIN),
                .rst      (RESET),
                .se       (SE),
                .req      (REQ[i]),
                .force_on (FORCE_ON[i]),
                .idle_lim (IDLE_LIM[i*IDLE_W +: IDLE_W]),
                .clk_out  (CLKOUT[i]),
                .ack      (ACK[i])
            );
        end
    endgenerate

endmodule
